// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver; new values are committed only at frame wrap.
// Define SSEG_DP_EN to add the per-digit decimal point (dp_in / dp ports).
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic [2:0]              digit_idx,
    output logic                    frame_done
`ifdef SSEG_DP_EN
    ,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp
`endif
);

    localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;

    logic [CW-1:0]           r_cnt;
    logic [2:0]              r_idx;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic [4*NUM_DIGITS-1:0] r_display;
    logic                    r_wrap;

    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic [2:0]              r_digit_idx;
    logic                    r_frame_done;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic [2:0]              w_idx_next;
    logic [31:0]             w_disp_pad;
    logic [3:0]              w_nib [0:7];
    logic [7:0]              w_hi_zero;
    logic [3:0]              w_cur_nib;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_an_dec;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    assign w_slot_end = (r_cnt == CW'(DWELL - 1));
    assign w_idx_next = (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
    assign w_wrap     = w_slot_end && (r_idx == 3'(NUM_DIGITS - 1));

    // Pad the display out to 8 digits so every per-digit lookup has a fixed width.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            if (gi < NUM_DIGITS) begin : g_live
                assign w_disp_pad[4*gi +: 4] = r_display[4*gi +: 4];
                assign w_an_dec[gi]          = (r_idx != 3'(gi));
            end else begin : g_pad
                assign w_disp_pad[4*gi +: 4] = 4'h0;
            end
            assign w_nib[gi]     = w_disp_pad[4*gi +: 4];
            assign w_hi_zero[gi] = (w_disp_pad[31:4*gi] == '0);
        end
    endgenerate

`ifdef SSEG_DP_EN
    logic [7:0] w_dp_pad;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dp
            if (gi < NUM_DIGITS) begin : g_live
                assign w_dp_pad[gi] = dp_in[gi];
            end else begin : g_pad
                assign w_dp_pad[gi] = 1'b0;
            end
        end
    endgenerate
`endif

    assign w_cur_nib = w_nib[r_idx];
    // Digit 0 always shows, so a zero value still displays a single 0.
    assign w_blank   = blank_lz && (r_idx != 3'd0) && w_hi_zero[r_idx];

    // Outputs are a one-cycle registered view of the scan position, so each slot spans DWELL cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= 3'd0;
            r_pending    <= '0;
            r_display    <= '0;
            r_wrap       <= 1'b0;
            r_an         <= '1;
            r_seg        <= 7'h7F;
            r_digit_idx  <= 3'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt  <= w_slot_end ? '0 : r_cnt + CW'(1);
            r_wrap <= w_wrap;
            if (w_slot_end) begin
                r_idx <= w_idx_next;
            end
            if (load) begin
                r_pending <= value;
            end
            if (w_wrap) begin
                r_display <= load ? value : r_pending;
            end
            r_an         <= w_blank ? '1 : w_an_dec;
            r_seg        <= w_blank ? 7'h7F : ~hex_to_seg(w_cur_nib);
            r_digit_idx  <= r_idx;
            r_frame_done <= r_wrap;
        end
    end

`ifdef SSEG_DP_EN
    logic r_dp;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dp <= 1'b1;
        end else begin
            r_dp <= w_blank ? 1'b1 : ~w_dp_pad[r_idx];
        end
    end
    assign dp = r_dp;
`endif

    assign an         = r_an;
    assign seg        = r_seg;
    assign digit_idx  = r_digit_idx;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Randomized scoreboard bench for sevenseg_scan_driver (NUM_DIGITS=4, DWELL=4).
module tb_sevenseg_scan_driver;
    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int FRAME = N * DW;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [2:0]  digit_idx;
    logic        frame_done;
`ifdef SSEG_DP_EN
    logic [3:0]  dp_in = 4'h0;
    logic        dp;
`endif

    sevenseg_scan_driver #(.NUM_DIGITS(N), .DWELL(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
`ifdef SSEG_DP_EN
        ,
        .dp_in      (dp_in),
        .dp         (dp)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [2:0] idx;
        logic       fd;
        logic       dp;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [6:0]  hex_tab [16];
    logic [15:0] m_pending = 16'h0;
    logic [15:0] m_display = 16'h0;
    int          m_k = 0;
    logic        g_blz = 1'b0;
    logic [3:0]  g_dpi = 4'h0;

    // Reference: cycle k after reset release shows digit ((k-1)/DWELL)%N; every FRAME-th cycle commits.
    task automatic step(input bit rst, input bit ld, input logic [15:0] v);
        exp_t       e;
        int         d;
        logic [3:0] nib;
        bit         blank;
        @(negedge clk);
        reset    = rst;
        load     = ld;
        value    = v;
        blank_lz = g_blz;
`ifdef SSEG_DP_EN
        dp_in    = g_dpi;
`endif
        if (rst) begin
            e.an = 4'hF; e.seg = 7'h7F; e.idx = 3'd0; e.fd = 1'b0; e.dp = 1'b1;
            m_pending = 16'h0;
            m_display = 16'h0;
            m_k = 0;
        end else begin
            m_k++;
            d     = ((m_k - 1) / DW) % N;
            nib   = 4'(m_display >> (4 * d));
            blank = g_blz && (d > 0) && ((m_display >> (4 * d)) == 16'h0);
            e.idx = 3'(d);
            e.fd  = (m_k > 1) && (((m_k - 1) % FRAME) == 0);
            if (blank) begin
                e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
            end else begin
                e.an = ~(4'(1 << d)); e.seg = ~hex_tab[nib]; e.dp = ~g_dpi[d];
            end
            if ((m_k % FRAME) == 0) m_display = ld ? v : m_pending;
            if (ld) begin
                m_pending = v;
                $display("load value=%h at cycle %0d", v, m_k);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        bit   bad;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                bad = (an !== e.an) || (seg !== e.seg) || (digit_idx !== e.idx) || (frame_done !== e.fd);
`ifdef SSEG_DP_EN
                bad = bad || (dp !== e.dp);
`endif
                vectors++;
                if (bad) begin
                    miscompares++;
                    $display("FAIL scan vec%0d: got an=%b seg=%h idx=%0d fd=%b, want an=%b seg=%h idx=%0d fd=%b dp=%b",
                             vectors, an, seg, digit_idx, frame_done, e.an, e.seg, e.idx, e.fd, e.dp);
                end
            end
        end
    end

    initial begin : stimulus
        hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        repeat (3) step(1'b1, 1'b0, 16'h0);

        // Scan/decode, then a mid-frame load at digit 1 and a load in the wrap cycle
        step(1'b0, 1'b1, 16'h1234);
        idle(2 * FRAME);
        while (((m_k / DW) % N) != 1) idle(1);
        step(1'b0, 1'b1, 16'hABCD);
        idle(FRAME + 4);
        while (((m_k + 1) % FRAME) != 0) idle(1);
        step(1'b0, 1'b1, 16'h1234);
        idle(FRAME);

        // Leading-zero blanking
        g_blz = 1'b1;
        step(1'b0, 1'b1, 16'h0005);
        idle(2 * FRAME);
        step(1'b0, 1'b1, 16'h0000);
        idle(2 * FRAME);
        g_blz = 1'b0;
        idle(FRAME);

        // Reset during digit 2
        step(1'b0, 1'b1, 16'h1234);
        idle(2 * FRAME);
        while (((m_k / DW) % N) != 2) idle(1);
        idle(1);
        step(1'b1, 1'b0, 16'h0);
        idle(FRAME + 2);

        // Upper hex range
        step(1'b0, 1'b1, 16'hFEDC);
        idle(2 * FRAME);

        // Decimal point
        g_dpi = 4'b0100;
        step(1'b0, 1'b1, 16'h1234);
        idle(2 * FRAME);
        g_blz = 1'b1;
        g_dpi = 4'b1000;
        step(1'b0, 1'b1, 16'h0034);
        idle(2 * FRAME);

        // Randomized traffic with leading-zero-heavy values
        for (int i = 0; i < 600; i++) begin
            logic [15:0] v;
            v = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 31) == 0) g_blz = 1'($urandom);
            g_dpi = 4'($urandom);
            if ($urandom_range(0, 99) == 0) step(1'b1, 1'b0, v);
            else step(1'b0, ($urandom_range(0, 7) == 0), v);
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
